// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by an on-chip word RAM: INCR bursts, 32-bit beats,
// with independent read and write channels.
module axi_ram_slave #(
    parameter int MEM_AW = 10
) (
    input  logic        clk,
    input  logic        resetn,
    // read address channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    logic [31:0]       mem [DEPTH];

    rd_state_t         rd_state, rd_next;
    logic [3:0]        rd_id;
    logic [MEM_AW-1:0] rd_idx;
    logic [7:0]        rd_len, rd_cnt;
    logic              ar_fire, r_fire;

    wr_state_t         wr_state, wr_next;
    logic [3:0]        wr_id;
    logic [MEM_AW-1:0] wr_idx;
    logic [7:0]        wr_len, wr_cnt;
    logic              wr_err;
    logic              aw_fire, w_fire, w_final;

    // Read FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rd_state <= RD_IDLE;
        else         rd_state <= rd_next;
    end

    // Read next-state and R-channel outputs; rdata reads the array directly
    // so a write to the current word shows up one cycle later
    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = '0;
        ar_fire = 1'b0;
        r_fire  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                arready = 1'b1;
                ar_fire = arvalid;
                if (arvalid) rd_next = RD_DATA;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                rid    = rd_id;
                rdata  = mem[rd_idx];
                rlast  = (rd_cnt == rd_len);
                r_fire = rready;
                if (rready && rlast) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read burst context: latched on AR handshake, advanced per R beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_id  <= '0;
            rd_idx <= '0;
            rd_len <= '0;
            rd_cnt <= '0;
        end else if (ar_fire) begin
            rd_id  <= arid;
            rd_idx <= araddr[MEM_AW+1:2];
            rd_len <= arlen;
            rd_cnt <= '0;
        end else if (r_fire) begin
            rd_idx <= rd_idx + 1'b1;
            rd_cnt <= rd_cnt + 8'd1;
        end
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wr_state <= WR_IDLE;
        else         wr_state <= wr_next;
    end

    // Write next-state and AW/W/B outputs; the burst length alone ends the burst
    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bid     = '0;
        bresp   = '0;
        aw_fire = 1'b0;
        w_fire  = 1'b0;
        w_final = (wr_cnt == wr_len);
        case (wr_state)
            WR_IDLE: begin
                awready = 1'b1;
                aw_fire = awvalid;
                if (awvalid) wr_next = WR_DATA;
            end
            WR_DATA: begin
                wready = 1'b1;
                w_fire = wvalid;
                if (wvalid && w_final) wr_next = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                bid    = wr_id;
                bresp  = wr_err ? 2'b10 : 2'b00;
                if (bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write burst context and wlast protocol-error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_id  <= '0;
            wr_idx <= '0;
            wr_len <= '0;
            wr_cnt <= '0;
            wr_err <= 1'b0;
        end else if (aw_fire) begin
            wr_id  <= awid;
            wr_idx <= awaddr[MEM_AW+1:2];
            wr_len <= awlen;
            wr_cnt <= '0;
            wr_err <= 1'b0;
        end else if (w_fire) begin
            wr_idx <= wr_idx + 1'b1;
            wr_cnt <= wr_cnt + 8'd1;
            if (wlast != w_final) wr_err <= 1'b1;
        end
    end

    // Byte-lane RAM write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave against a word-array memory model.
module tb_axi_ram_slave;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int WAIT  = 50;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    logic [31:0] model [DEPTH];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    axi_ram_slave #(.MEM_AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    function automatic int word_of(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    // Write burst from wbuf/sbuf; bad_beat (if within the burst) gets an inverted wlast
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int bad_beat);
        int n;
        int idx;
        logic exp_err;
        logic [31:0] w;
        idx = word_of(addr);
        exp_err = (bad_beat >= 0) && (bad_beat <= len);
        @(negedge clk);
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        n = 0;
        while (!awready && n < WAIT) begin @(negedge clk); n++; end
        vectors++;
        if (awready !== 1'b1) begin
            miscompares++;
            $display("FAIL aw_accept: awready=%b required 1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i];
            wlast = (i == len) ^ (i == bad_beat);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < WAIT) begin @(negedge clk); n++; end
            vectors++;
            if (wready !== 1'b1) begin
                miscompares++;
                $display("FAIL w_accept beat %0d: wready=%b required 1", i, wready);
            end
            w = model[(idx + i) % DEPTH];
            for (int b = 0; b < 4; b++)
                if (sbuf[i][b]) w[8*b +: 8] = wbuf[i][8*b +: 8];
            model[(idx + i) % DEPTH] = w;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < WAIT) begin @(negedge clk); n++; end
        vectors++;
        if (bvalid !== 1'b1 || bid !== id || bresp !== (exp_err ? 2'b10 : 2'b00)) begin
            miscompares++;
            $display("FAIL b_resp: bvalid=%b bid=%0d bresp=%b required 1 %0d %b",
                     bvalid, bid, bresp, id, exp_err ? 2'b10 : 2'b00);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        vectors++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            miscompares++;
            $display("FAIL b_done: bvalid=%b awready=%b required 0 1", bvalid, awready);
        end
    endtask

    // Read burst checked against the model, with a fixed stall or random stalls
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int stall_beat, input int stall_cycles, input bit rand_stall);
        int n;
        int idx;
        int stalls;
        logic [31:0] exp;
        idx = word_of(addr);
        @(negedge clk);
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < WAIT) begin @(negedge clk); n++; end
        vectors++;
        if (arready !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_accept: arready=%b required 1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            exp = model[(idx + i) % DEPTH];
            n = 0;
            while (!rvalid && n < WAIT) begin @(negedge clk); n++; end
            vectors++;
            if (rvalid !== 1'b1 || rdata !== exp || rid !== id || rresp !== 2'b00
                || rlast !== (i == len)) begin
                miscompares++;
                $display("FAIL r_beat %0d: rvalid=%b rdata=%h rid=%0d rresp=%b rlast=%b required 1 %h %0d 00 %b",
                         i, rvalid, rdata, rid, rresp, rlast, exp, id, (i == len));
            end
            stalls = (i == stall_beat) ? stall_cycles : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < stalls; s++) begin
                @(negedge clk);
                vectors++;
                if (rvalid !== 1'b1 || rdata !== exp || rid !== id || rlast !== (i == len)) begin
                    miscompares++;
                    $display("FAIL r_hold beat %0d: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                             i, rvalid, rdata, rlast, exp, (i == len));
                end
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        vectors++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || rdata !== 32'h0 || rlast !== 1'b0) begin
            miscompares++;
            $display("FAIL r_done: rvalid=%b arready=%b rdata=%h rlast=%b required 0 1 0 0",
                     rvalid, arready, rdata, rlast);
        end
    endtask

    task automatic check_idle(input string tag);
        vectors++;
        if (arready !== 1'b1 || awready !== 1'b1 || rvalid !== 1'b0 || wready !== 1'b0
            || bvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'h0 || rid !== 4'h0
            || rresp !== 2'b00 || bid !== 4'h0 || bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL %s: arready=%b awready=%b rvalid=%b wready=%b bvalid=%b rlast=%b rdata=%h rid=%0d rresp=%b bid=%0d bresp=%b required 1 1 0 0 0 0 0 0 0 0 0",
                     tag, arready, awready, rvalid, wready, bvalid, rlast, rdata, rid, rresp, bid, bresp);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1 check_idle("reset_asserted");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_idle("reset_released");
    endtask

    task automatic test_basic_burst();
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        do_write(4'd1, 32'h40, 3, -1);
        do_read(4'd0, 32'h40, 3, -1, 0, 1'b0);
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(4'd2, 32'h20, 0, -1);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0011;
        do_write(4'd3, 32'h20, 0, -1);
        do_read(4'd4, 32'h20, 0, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        do_write(4'd5, 32'h100, 3, -1);
        do_read(4'd6, 32'h100, 3, 1, 3, 1'b0);
    endtask

    task automatic test_wlast_error();
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        do_write(4'd7, 32'h200, 3, 1);
        do_read(4'd8, 32'h200, 3, -1, 0, 1'b0);
    endtask

    task automatic test_wrap_and_reset();
        int n;
        wbuf[0] = 32'hFEEDF00D; sbuf[0] = 4'hF;
        do_write(4'd9, 32'hFFC, 0, -1);
        wbuf[0] = 32'h0BADCAFE;
        do_write(4'd10, 32'h0, 0, -1);
        @(negedge clk);
        arid = 4'd11; araddr = 32'h12345FFC; arlen = 8'd1; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== model[DEPTH-1] || rlast !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_beat1: rvalid=%b rdata=%h rlast=%b required 1 %h 0",
                     rvalid, rdata, rlast, model[DEPTH-1]);
        end
        @(negedge clk);
        rready = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== model[0] || rlast !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_beat2: rvalid=%b rdata=%h rlast=%b required 1 %h 1",
                     rvalid, rdata, rlast, model[0]);
        end
        resetn = 1'b0;
        #1 check_idle("midburst_reset");
        n = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_idle("after_midburst_reset");
        do_read(4'd12, 32'h40, 3, -1, 0, 1'b0);
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'(i + 8); end
        fork
            do_write(4'd13, 32'h300, 7, -1);
            do_read(4'd14, 32'h100, 3, -1, 0, 1'b1);
        join
        do_read(4'd15, 32'h300, 7, -1, 0, 1'b1);
    endtask

    task automatic test_random();
        int len;
        int bad;
        logic [31:0] addr;
        for (int t = 0; t < 12; t++) begin
            len  = int'($urandom_range(0, 15));
            addr = $urandom;
            bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
            for (int i = 0; i <= len; i++) begin
                wbuf[i] = $urandom;
                sbuf[i] = (t < 3) ? 4'hF : 4'($urandom);
            end
            do_write(4'($urandom), addr, len, bad);
            do_read(4'($urandom), addr, len, -1, 0, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        resetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        test_reset();
        test_basic_burst();
        test_strobe();
        test_backpressure();
        test_wlast_error();
        test_wrap_and_reset();
        test_concurrent();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
